jt49_wrsched: RTL
=================

// Module: jt49_wrsched
// PURPOSE
//  Buffers CPU register writes to the JT49 PSG core and issues them to the core in sync with the cen16 tick.
//  It sits between the bus interface and the PSG register file.
//  It guarantees at most one register update per GAP cen16 slots.
//  It presents a ready/valid style back-pressure to the CPU side.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, 2..16
//  GAP     1   minimum cen16 pulses between consecutive psg_we strobes; 1..15
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset; asynchronous, active-high
//  cen16      in   1   tone-rate clock enable from the cen divider; single-cycle pulse
//  cpu_wr     in   1   write request; accepted when cpu_wr & cpu_ready
//  cpu_addr   in   4   PSG register address
//  cpu_din    in   8   PSG register data
//  cpu_ready  out  1   write can be accepted this cycle
//  flush      in   1   discard all queued writes, abort hold-off
//  ovf_clr    in   1   clears ovf
//  psg_we     out  1   one-cycle write strobe to PSG core
//  psg_addr   out  4   address for psg_we; held until the next strobe
//  psg_dout   out  8   data for psg_we; held until the next strobe
//  level      out  $clog2(DEPTH)+1   entries currently queued
//  ovf        out  1   sticky: a write arrived while cpu_ready=0
// BEHAVIOUR
//  Reset values: psg_we=0, psg_addr=0, psg_dout=0, level=0, ovf=0, cpu_ready=1.
//  After reset: FIFO empty, FSM in IDLE, hold-off counter=0.
//  - All outputs except cpu_ready are registered.
//  - cpu_ready is combinational: !full (see CONFIGURATION for the coalesce extension).
//  - Push and pop in the same cycle:
//    - Push is blocked when full, even if a pop occurs that cycle.
//    - Push into an empty FIFO is never popped in the same cycle.
//  - cpu_wr while cpu_ready=0: write dropped, ovf<=1.
//    - ovf_clr and a new overflow in the same cycle: ovf stays 1.
//  FSM:
//    IDLE  : on cen16 & level!=0 -> pop head, load psg_addr/psg_dout -> STRB
//    STRB  : psg_we=1 for exactly this cycle -> HOLD (cnt<=GAP-1), or IDLE if GAP==1
//    HOLD  : each cen16 decrements cnt; on cen16 with cnt==1 -> IDLE
//            the cen16 that moves HOLD->IDLE does not issue; issue waits for the next cen16
//  - Latency: a write accepted at cycle N with an idle, empty scheduler gives psg_we one cycle
//    after the first cen16 at cycle >= N+1.
//  - Ordering: strict FIFO. Pointers wrap modulo DEPTH. level saturates at neither end;
//    the full/empty logic prevents over/underflow.
//  - cen16 asserted in STRB: ignored. cen16 high continuously: one issue per GAP+1 cycles minimum.
//  - flush:
//    - Sets level=0 and FSM to IDLE from any state.
//    - A psg_we already asserted in the flush cycle completes.
//    - flush has priority over a same-cycle push: the push is discarded and ovf is not set.
//    - flush has priority over a same-cycle pop: no strobe follows.
//  - Reset mid-operation: immediate return to reset values. A strobe in progress is cut.
// CONFIGURATION
//  JT49_WRSCHED_COALESCE_EN defined:
//    - A push whose cpu_addr matches a queued entry overwrites that entry's data in place.
//      level and queue position are unchanged.
//    - The head being popped in the same cycle is excluded from matching.
//    - cpu_ready = !full | match. It depends combinationally on cpu_addr.
//    - When several entries match, the youngest is updated.
//  Undefined: every accepted write takes its own entry and cpu_ready = !full.
// TESTING
//  1. Reset, push (addr 7, 0x38) at cycle 2, cen16 at cycle 10
//     -> psg_we only at cycle 11, addr=7, data=0x38; level returns to 0.
//  2. GAP=3, push 3 writes back-to-back, cen16 every 8 clocks
//     -> strobes on the 1st, 4th and 7th cen16 (+1 cycle), in push order.
//  3. DEPTH=4, push 5 writes with no cen16
//     -> cpu_ready=0 after the 4th; 5th dropped, ovf=1; ovf_clr -> ovf=0.
//  4. Queue 3 writes, assert flush together with cen16 and a push
//     -> no psg_we follows, level=0, ovf=0, the pushed write is lost.
//  5. COALESCE_EN: queue (2,0x10), (5,0x20), then (2,0x11) while full
//     -> accepted, level unchanged; issue order (2,0x11), (5,0x20).
//  6. Assert rst during HOLD with 2 entries queued
//     -> outputs at reset values immediately; no strobe until new writes arrive.

Source files
------------

// File: rtl/jt49_wrsched.sv
// Write scheduler for the JT49 PSG: queues CPU register writes and issues them on cen16 ticks.
// Optional build macro JT49_WRSCHED_COALESCE_EN merges writes to an already-queued address.
module jt49_wrsched #(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen16,
  input  logic                     cpu_wr,
  input  logic [3:0]               cpu_addr,
  input  logic [7:0]               cpu_din,
  output logic                     cpu_ready,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     psg_we,
  output logic [3:0]               psg_addr,
  output logic [7:0]               psg_dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    STRB,
    HOLD
  } state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [3:0]    q_addr [DEPTH];
  logic [7:0]    q_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          full, pop, push, push_new, match;
  logic [PW-1:0] match_idx;

  assign full = (level == LW'(DEPTH));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (cen16 && level != '0) begin
          pop     = 1'b1;
          state_d = STRB;
        end
      end
      STRB: begin
        if (GAP == 1) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          cnt_d   = 4'(GAP - 1);
        end
      end
      HOLD: begin
        if (cen16) begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      pop     = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

`ifdef JT49_WRSCHED_COALESCE_EN
  logic [PW-1:0] scan_idx;

  // Scan oldest to youngest so the last hit wins; the head leaving this cycle is skipped.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + PW'(k);
      if (LW'(k) < level && q_addr[scan_idx] == cpu_addr && !(k == 0 && pop)) begin
        match     = 1'b1;
        match_idx = scan_idx;
      end
    end
  end

  assign cpu_ready = !full || match;
`else
  assign match     = 1'b0;
  assign match_idx = '0;
  assign cpu_ready = !full;
`endif

  assign push     = cpu_wr && cpu_ready && !flush;
  assign push_new = push && !match;

  always_ff @(posedge clk) begin
    if (push_new) begin
      q_addr[wr_ptr] <= cpu_addr;
      q_data[wr_ptr] <= cpu_din;
    end else if (push) begin
      q_data[match_idx] <= cpu_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      psg_we   <= 1'b0;
      psg_addr <= '0;
      psg_dout <= '0;
      ovf      <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      psg_we <= pop;
      if (pop) begin
        psg_addr <= q_addr[rd_ptr];
        psg_dout <= q_data[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_new) wr_ptr <= wr_ptr + PW'(1);
        if (pop)      rd_ptr <= rd_ptr + PW'(1);
        level <= level + LW'(push_new) - LW'(pop);
      end
      if (ovf_clr) ovf <= 1'b0;
      if (cpu_wr && !cpu_ready && !flush) ovf <= 1'b1;
    end
  end

endmodule
